// File: rtl/acc_adder_pkg.sv
// Shared definitions for the accumulating adder.
//   op_e : operation encoding carried on the 2-bit op port
//   OP_W : width of the op port
package acc_adder_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    ACC = 2'd2,
    CLR = 2'd3
  } op_e;

endpackage

// File: rtl/acc_adder_if.sv
// Bundle of every non-parameter port of acc_adder, used to hook the block into benches.
//   clk, rst_n          : clock and asynchronous active-low reset (interface ports)
//   in_valid/in_ready   : request handshake, op/a/b request payload
//   out_valid/out_ready : result handshake, y/carry result payload
//   acc                 : current accumulator value
interface acc_adder_if
  import acc_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic clk,
  input logic rst_n
);

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic [WIDTH-1:0] acc;

  modport dut (
    input  clk, rst_n, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, carry, acc
  );

  modport drv (
    input  clk, rst_n, in_ready, out_valid, y, carry, acc,
    output in_valid, op, a, b, out_ready
  );

endinterface

// File: rtl/acc_adder_addsub_core.sv
// Combinational arithmetic datapath of acc_adder.
//   i_op    : operation (op_e encoding)
//   i_a     : operand A
//   i_b     : operand B (ADD/SUB only)
//   i_acc   : current accumulator (ACC only)
//   o_y     : result, saturated when SAT != 0
//   o_carry : raw carry-out (ADD/ACC) or borrow (SUB), never affected by saturation
module addsub_core
  import acc_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SAT   = 0
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0] o_y,
  output logic             o_carry
);

  localparam bit SatEn = (SAT != 0);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum   = '0;
    o_y     = '0;
    o_carry = 1'b0;
    case (op_e'(i_op))
      ADD: begin
        w_sum   = {1'b0, i_a} + {1'b0, i_b};
        o_carry = w_sum[WIDTH];
        o_y     = (SatEn && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0];
      end
      SUB: begin
        // Top bit of the WIDTH+1 difference is set exactly when a < b.
        w_sum   = {1'b0, i_a} - {1'b0, i_b};
        o_carry = w_sum[WIDTH];
        o_y     = (SatEn && w_sum[WIDTH]) ? '0 : w_sum[WIDTH-1:0];
      end
      ACC: begin
        w_sum   = {1'b0, i_acc} + {1'b0, i_a};
        o_carry = w_sum[WIDTH];
        o_y     = (SatEn && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0];
      end
      CLR: begin
        o_y     = '0;
        o_carry = 1'b0;
      end
      default: begin
        o_y     = '0;
        o_carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/acc_adder.sv
// Registered add/subtract/accumulate unit with valid/ready handshakes on both sides.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake; in_ready = !out_valid || out_ready
//   op, a, b            : operation and operands (b ignored for ACC/CLR)
//   out_valid/out_ready : result handshake; result held while stalled
//   y, carry            : registered result and carry/borrow
//   acc                 : accumulator register (written by ACC and CLR only)
module acc_adder
  import acc_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic [WIDTH-1:0] acc
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;

  logic             w_fire;
  logic [WIDTH-1:0] w_core_y;
  logic             w_core_carry;
  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_acc_nxt;

  addsub_core #(
    .WIDTH (WIDTH),
    .SAT   (SAT)
  ) u_core (
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .i_acc   (r_acc),
    .o_y     (w_core_y),
    .o_carry (w_core_carry)
  );

  // A stalled result blocks new beats, which also freezes the accumulator.
  assign in_ready = !r_out_valid || out_ready;
  assign w_fire   = in_valid && in_ready;

  always_comb begin
    w_out_valid_nxt = r_out_valid;
    w_y_nxt         = r_y;
    w_carry_nxt     = r_carry;
    w_acc_nxt       = r_acc;
    if (w_fire) begin
      w_out_valid_nxt = 1'b1;
      w_y_nxt         = w_core_y;
      w_carry_nxt     = w_core_carry;
      // CLR yields y = 0, so both ACC and CLR can load the core result.
      if (op == ACC || op == CLR) begin
        w_acc_nxt = w_core_y;
      end
    end else if (out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_carry     <= 1'b0;
      r_acc       <= '0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_y         <= w_y_nxt;
      r_carry     <= w_carry_nxt;
      r_acc       <= w_acc_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign carry     = r_carry;
  assign acc       = r_acc;

endmodule

// File: tb/tb_acc_adder.sv
// Bench for acc_adder: four instances (WIDTH 4/8 x SAT 0/1). Instances of equal width share
// stimulus; a scoreboard queue per width holds the expected result of both SAT variants.
module tb_acc_adder;

  typedef struct packed {
    logic [1:0][31:0] y;
    logic [1:0]       c;
  } exp_t;

  logic clk;
  logic rst_n;

  // Group A (WIDTH 4) and group B (WIDTH 8) stimulus.
  logic       va, ra, vb, rb;
  logic [1:0] opa, opb;
  logic [3:0] aa, ba;
  logic [7:0] ab, bb;

  int checks   = 0;
  int failures = 0;
  int nb_fired = 0;
  int nb_drain = 0;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] macc[4];

  logic [31:0] o_y[4];
  logic [31:0] o_acc[4];
  logic        o_valid[4];
  logic        o_rdy[4];
  logic        o_c[4];

  acc_adder_if #(.WIDTH(4)) ifa0 (.clk(clk), .rst_n(rst_n));
  acc_adder_if #(.WIDTH(4)) ifa1 (.clk(clk), .rst_n(rst_n));
  acc_adder_if #(.WIDTH(8)) ifb0 (.clk(clk), .rst_n(rst_n));
  acc_adder_if #(.WIDTH(8)) ifb1 (.clk(clk), .rst_n(rst_n));

  assign ifa0.in_valid = va;  assign ifa1.in_valid = va;
  assign ifa0.out_ready = ra; assign ifa1.out_ready = ra;
  assign ifa0.op = opa;       assign ifa1.op = opa;
  assign ifa0.a = aa;         assign ifa1.a = aa;
  assign ifa0.b = ba;         assign ifa1.b = ba;
  assign ifb0.in_valid = vb;  assign ifb1.in_valid = vb;
  assign ifb0.out_ready = rb; assign ifb1.out_ready = rb;
  assign ifb0.op = opb;       assign ifb1.op = opb;
  assign ifb0.a = ab;         assign ifb1.a = ab;
  assign ifb0.b = bb;         assign ifb1.b = bb;

  acc_adder #(.WIDTH(4), .SAT(0)) u_a0 (
    .clk(ifa0.clk), .rst_n(ifa0.rst_n), .in_valid(ifa0.in_valid), .in_ready(ifa0.in_ready),
    .op(ifa0.op), .a(ifa0.a), .b(ifa0.b), .out_valid(ifa0.out_valid),
    .out_ready(ifa0.out_ready), .y(ifa0.y), .carry(ifa0.carry), .acc(ifa0.acc)
  );
  acc_adder #(.WIDTH(4), .SAT(1)) u_a1 (
    .clk(ifa1.clk), .rst_n(ifa1.rst_n), .in_valid(ifa1.in_valid), .in_ready(ifa1.in_ready),
    .op(ifa1.op), .a(ifa1.a), .b(ifa1.b), .out_valid(ifa1.out_valid),
    .out_ready(ifa1.out_ready), .y(ifa1.y), .carry(ifa1.carry), .acc(ifa1.acc)
  );
  acc_adder #(.WIDTH(8), .SAT(0)) u_b0 (
    .clk(ifb0.clk), .rst_n(ifb0.rst_n), .in_valid(ifb0.in_valid), .in_ready(ifb0.in_ready),
    .op(ifb0.op), .a(ifb0.a), .b(ifb0.b), .out_valid(ifb0.out_valid),
    .out_ready(ifb0.out_ready), .y(ifb0.y), .carry(ifb0.carry), .acc(ifb0.acc)
  );
  acc_adder #(.WIDTH(8), .SAT(1)) u_b1 (
    .clk(ifb1.clk), .rst_n(ifb1.rst_n), .in_valid(ifb1.in_valid), .in_ready(ifb1.in_ready),
    .op(ifb1.op), .a(ifb1.a), .b(ifb1.b), .out_valid(ifb1.out_valid),
    .out_ready(ifb1.out_ready), .y(ifb1.y), .carry(ifb1.carry), .acc(ifb1.acc)
  );

  always_comb begin
    o_y[0] = 32'(ifa0.y);   o_y[1] = 32'(ifa1.y);   o_y[2] = 32'(ifb0.y);   o_y[3] = 32'(ifb1.y);
    o_acc[0] = 32'(ifa0.acc); o_acc[1] = 32'(ifa1.acc);
    o_acc[2] = 32'(ifb0.acc); o_acc[3] = 32'(ifb1.acc);
    o_valid[0] = ifa0.out_valid; o_valid[1] = ifa1.out_valid;
    o_valid[2] = ifb0.out_valid; o_valid[3] = ifb1.out_valid;
    o_rdy[0] = ifa0.in_ready; o_rdy[1] = ifa1.in_ready;
    o_rdy[2] = ifb0.in_ready; o_rdy[3] = ifb1.in_ready;
    o_c[0] = ifa0.carry; o_c[1] = ifa1.carry; o_c[2] = ifb0.carry; o_c[3] = ifb1.carry;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, inst, obs, expv);
    end
  endtask

  // Reference arithmetic, written independently of the datapath structure.
  function automatic void model(input int unsigned w, input bit sat, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] acc, output logic [31:0] y,
                                output logic c, output logic [31:0] nacc);
    logic [32:0] full;
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    full = '0;
    y    = '0;
    c    = 1'b0;
    nacc = acc;
    case (op)
      2'd0: begin
        full = {1'b0, a} + {1'b0, b};
        c    = full[w];
        y    = (sat && c) ? mask : (full[31:0] & mask);
      end
      2'd1: begin
        c = (a < b);
        y = (sat && c) ? 32'd0 : ((a - b) & mask);
      end
      2'd2: begin
        full = {1'b0, acc} + {1'b0, a};
        c    = full[w];
        y    = (sat && c) ? mask : (full[31:0] & mask);
        nacc = y;
      end
      default: begin
        y    = '0;
        c    = 1'b0;
        nacc = '0;
      end
    endcase
  endfunction

  task automatic inst_check(input int i);
    int   qs;
    bit   r;
    exp_t e;
    qs = (i < 2) ? qa.size() : qb.size();
    r  = (i < 2) ? ra : rb;
    chk("out_valid", i, 32'(o_valid[i]), 32'(qs != 0));
    chk("in_ready", i, 32'(o_rdy[i]), 32'((qs == 0) || r));
    chk("acc", i, o_acc[i], macc[i]);
    if (qs != 0) begin
      e = (i < 2) ? qa[0] : qb[0];
      chk("y", i, o_y[i], e.y[i%2]);
      chk("carry", i, 32'(o_c[i]), 32'(e.c[i%2]));
    end
  endtask

  // One clock: check all instances and update the scoreboard at the negedge, then return
  // 1 time unit after the following posedge so the caller can drive new inputs.
  task automatic step();
    exp_t        e;
    logic [31:0] yy, na;
    logic        cc;
    bit          fa, fb;
    @(negedge clk);
    for (int i = 0; i < 4; i++) inst_check(i);
    if (rst_n) begin
      fa = va && (qa.size() == 0 || ra);
      fb = vb && (qb.size() == 0 || rb);
      if (qa.size() != 0 && ra) void'(qa.pop_front());
      if (qb.size() != 0 && rb) begin
        void'(qb.pop_front());
        nb_drain++;
      end
      if (fa) begin
        e = '0;
        for (int k = 0; k < 2; k++) begin
          model(4, k[0], opa, 32'(aa), 32'(ba), macc[k], yy, cc, na);
          e.y[k] = yy; e.c[k] = cc; macc[k] = na;
        end
        qa.push_back(e);
      end
      if (fb) begin
        e = '0;
        for (int k = 0; k < 2; k++) begin
          model(8, k[0], opb, 32'(ab), 32'(bb), macc[2+k], yy, cc, na);
          e.y[k] = yy; e.c[k] = cc; macc[2+k] = na;
        end
        qb.push_back(e);
        nb_fired++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    for (int i = 0; i < 4; i++) macc[i] = '0;
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, i, 32'(o_valid[i]), 32'd0);
      chk({tag, "_y"}, i, o_y[i], 32'd0);
      chk({tag, "_carry"}, i, 32'(o_c[i]), 32'd0);
      chk({tag, "_acc"}, i, o_acc[i], 32'd0);
      chk({tag, "_rdy"}, i, 32'(o_rdy[i]), 32'd1);
    end
  endtask

  task automatic beat_a(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    va = 1'b1; opa = op; aa = a; ba = b;
    step();
  endtask

  logic [3:0]  acc_a[3];
  logic [31:0] acc_y0[3];
  logic [31:0] acc_y1[3];
  logic        acc_c0[3];
  int          cyc;

  initial begin
    va = 0; ra = 1; opa = 0; aa = 0; ba = 0;
    vb = 0; rb = 1; opb = 0; ab = 0; bb = 0;
    clear_model();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    step();
    step();
    rst_n = 1'b1;

    // Wrap vs. saturate on ADD overflow, then SUB borrow; first beat right after release.
    beat_a(2'd0, 4'd4, 4'd12);
    chk("add_valid", 0, 32'(o_valid[0]), 32'd1);
    chk("add_y_wrap", 0, o_y[0], 32'h0);
    chk("add_c_wrap", 0, 32'(o_c[0]), 32'd1);
    chk("add_y_sat", 1, o_y[1], 32'hf);
    chk("add_c_sat", 1, 32'(o_c[1]), 32'd1);
    beat_a(2'd1, 4'd2, 4'd5);
    chk("sub_y_wrap", 0, o_y[0], 32'd13);
    chk("sub_y_sat", 1, o_y[1], 32'd0);
    chk("sub_c_sat", 1, 32'(o_c[1]), 32'd1);

    // CLR, then three back-to-back ACC beats.
    beat_a(2'd3, 4'd9, 4'd9);
    chk("clr_y", 0, o_y[0], 32'd0);
    chk("clr_acc", 0, o_acc[0], 32'd0);
    acc_a[0] = 4'd5;  acc_a[1] = 4'd7;  acc_a[2] = 4'd6;
    acc_y0[0] = 32'd5; acc_y0[1] = 32'd12; acc_y0[2] = 32'd2;
    acc_y1[0] = 32'd5; acc_y1[1] = 32'd12; acc_y1[2] = 32'd15;
    acc_c0[0] = 1'b0; acc_c0[1] = 1'b0; acc_c0[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      beat_a(2'd2, acc_a[k], 4'd0);
      chk("acc_valid", 0, 32'(o_valid[0]), 32'd1);
      chk("acc_y_wrap", 0, o_y[0], acc_y0[k]);
      chk("acc_c_wrap", 0, 32'(o_c[0]), 32'(acc_c0[k]));
      chk("acc_y_sat", 1, o_y[1], acc_y1[k]);
    end
    va = 1'b0;
    step();
    chk("acc_end", 0, o_acc[0], 32'd2);
    chk("acc_end_sat", 1, o_acc[1], 32'd15);
    chk("acc_drained", 0, 32'(o_valid[0]), 32'd0);

    // Output stall: result held, second beat refused until out_ready returns.
    ra = 1'b0;
    beat_a(2'd0, 4'd2, 4'd5);
    opa = 2'd0; aa = 4'd1; ba = 4'd1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_y", 0, o_y[0], 32'd7);
      chk("stall_rdy", 0, 32'(o_rdy[0]), 32'd0);
      chk("stall_valid", 0, 32'(o_valid[0]), 32'd1);
    end
    ra = 1'b1;
    step();
    chk("unstall_y", 0, o_y[0], 32'd2);
    va = 1'b0;
    step();
    chk("unstall_empty", 0, 32'(o_valid[0]), 32'd0);

    // Asynchronous reset in the middle of a stall with acc = 9.
    beat_a(2'd3, 4'd0, 4'd0);
    beat_a(2'd2, 4'd9, 4'd0);
    ra = 1'b0;
    beat_a(2'd0, 4'd1, 4'd1);
    step();
    chk("pre_rst_acc", 0, o_acc[0], 32'd9);
    chk("pre_rst_valid", 0, 32'(o_valid[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    clear_model();
    va = 1'b0;
    ra = 1'b1;
    step();
    step();
    // Release with a beat already waiting: it fires on the first edge after release.
    va = 1'b1; opa = 2'd0; aa = 4'd3; ba = 4'd4;
    rst_n = 1'b1;
    step();
    chk("first_fire_y", 0, o_y[0], 32'd7);
    chk("first_fire_valid", 0, 32'(o_valid[0]), 32'd1);
    va = 1'b0;
    step();

    // Random traffic on the 8-bit pair.
    nb_fired = 0;
    nb_drain = 0;
    cyc = 0;
    while (nb_fired < 1000 && cyc < 20000) begin
      vb  = ($urandom_range(0, 3) != 0);
      rb  = ($urandom_range(0, 3) != 0);
      opb = 2'($urandom_range(0, 3));
      ab  = 8'($urandom_range(0, 255));
      bb  = 8'($urandom_range(0, 255));
      step();
      cyc++;
    end
    chk("rand_beats", 0, 32'(nb_fired), 32'd1000);
    vb = 1'b0;
    rb = 1'b1;
    step();
    step();
    chk("rand_queue_empty", 2, 32'(qb.size()), 32'd0);
    chk("rand_drained", 2, 32'(nb_drain), 32'd1000);
    chk("rand_idle", 2, 32'(o_valid[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
